// File: rtl/div_seq.sv
// Sequential signed divider: restoring shift-subtract on magnitudes, then one sign-fix cycle.
// Latency: done pulses WIDTH+2 cycles after start (2 with DIV_FAST_EXIT_EN when |a|<|b|); no backpressure.
// Optional feature macro: DIV_FAST_EXIT_EN (skip iteration when the dividend magnitude is below the divisor's).
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] hi_out,
    output logic             div_zero,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [WIDTH-1:0] dvd_q, dvd_d, rem_q, rem_d, dsr_q, dsr_d;
    logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgnq_q, sgnq_d, sgnr_q, sgnr_d;
    logic             dz_q, dz_d, done_q, done_d;

    logic [WIDTH-1:0] op_a, op_b, mag_a, mag_b;
    logic [WIDTH:0]   rem_sh, rem_diff;
    logic             q_bit;

    // Same-cycle load and start divides the live inputs rather than the stale registers.
    assign op_a  = load ? a_in : opa_q;
    assign op_b  = load ? b_in : opb_q;
    assign mag_a = op_a[WIDTH-1] ? -op_a : op_a;
    assign mag_b = op_b[WIDTH-1] ? -op_b : op_b;

    // One extra bit keeps the trial subtraction exact for the full unsigned magnitude range.
    assign rem_sh   = {rem_q, dvd_q[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, dsr_q};
    assign q_bit    = ~rem_diff[WIDTH];

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        sgnq_d  = sgnq_q;
        sgnr_d  = sgnr_q;
        dz_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    opa_d = a_in;
                    opb_d = b_in;
                end
                if (start) begin
                    if (op_b == '0) begin
                        dz_d = 1'b1;
                    end else begin
                        dvd_d   = mag_a;
                        dsr_d   = mag_b;
                        sgnq_d  = op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        sgnr_d  = op_a[WIDTH-1];
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = RUN;
`ifdef DIV_FAST_EXIT_EN
                        if (mag_a < mag_b) begin
                            dvd_d   = '0;
                            rem_d   = mag_a;
                            state_d = FIX;
                        end
`endif
                    end
                end
            end
            RUN: begin
                rem_d = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                dvd_d = {dvd_q[WIDTH-2:0], q_bit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                lo_d    = sgnq_q ? -dvd_q : dvd_q;
                hi_d    = sgnr_q ? -rem_q : rem_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            sgnq_q  <= 1'b0;
            sgnr_q  <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            sgnq_q  <= sgnq_d;
            sgnr_q  <= sgnr_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign lo_out   = lo_q;
    assign hi_out   = hi_q;
    assign div_zero = dz_q;
    assign done     = done_q;
    assign busy     = (state_q != IDLE);

endmodule
